// File: rtl/seq_fetch_unit.sv
// Multi-cycle byte-serial fetch stage for the SEQ Y86-64 core.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module seq_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] IMEM_LIMIT = 64'h1000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic [63:0] pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] instr_cnt,
  output logic [31:0] wait_cnt,
`endif
  input  logic        pc_load,
  input  logic [63:0] newPC
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_OUT   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       len_of = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd1;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  idx_q, idx_d, len_q, len_d, cur_len;
  logic        req_q, req_d, valid_q, valid_d;
  // Working copies filled byte by byte; published only on entry to OUT.
  logic [3:0]  f_icode_q, f_icode_d, f_ifun_q, f_ifun_d, f_ra_q, f_ra_d, f_rb_q, f_rb_d;
  logic [63:0] f_valc_q, f_valc_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic [2:0]  stat_q, stat_d;
  logic        pub_ok, pub_adr;
  logic [2:0]  vpos;
  logic [63:0] next_addr;

  assign next_addr = pc_q + 64'(idx_q) + 64'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    len_d     = len_q;
    req_d     = req_q;
    valid_d   = valid_q;
    f_icode_d = f_icode_q;
    f_ifun_d  = f_ifun_q;
    f_ra_d    = f_ra_q;
    f_rb_d    = f_rb_q;
    f_valc_d  = f_valc_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    valc_d    = valc_q;
    valp_d    = valp_q;
    stat_d    = stat_q;
    pub_ok    = 1'b0;
    pub_adr   = 1'b0;
    cur_len   = len_q;
    vpos      = 3'd0;
    case (state_q)
      ST_FETCH: begin
        if (!req_q) begin
          if (pc_q >= IMEM_LIMIT) pub_adr = 1'b1;
          else                    req_d   = 1'b1;
        end else if (imem_ack) begin
          if (imem_err) begin
            pub_adr = 1'b1;
          end else begin
            if (idx_q == 4'd0) begin
              f_icode_d = imem_rdata[7:4];
              f_ifun_d  = imem_rdata[3:0];
              cur_len   = len_of(imem_rdata[7:4]);
              len_d     = cur_len;
            end else if (idx_q == 4'd1 && cur_len != 4'd9) begin
              f_ra_d = imem_rdata[7:4];
              f_rb_d = imem_rdata[3:0];
            end else begin
              // valC starts at byte 1 for 9-byte forms, byte 2 for 10-byte forms.
              vpos = 3'(idx_q - ((cur_len == 4'd9) ? 4'd1 : 4'd2));
              f_valc_d[{vpos, 3'b000} +: 8] = imem_rdata;
            end
            if (idx_q + 4'd1 == cur_len)       pub_ok  = 1'b1;
            else if (next_addr >= IMEM_LIMIT)  pub_adr = 1'b1;
            else                               idx_d   = idx_q + 4'd1;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = (stat_q == STAT_AOK) ? ST_WAIT : ST_STOP;
        end
      end
      ST_WAIT: begin
        if (pc_load) begin
          pc_d      = newPC;
          idx_d     = 4'd0;
          len_d     = 4'd1;
          f_icode_d = 4'h0;
          f_ifun_d  = 4'h0;
          f_ra_d    = 4'hF;
          f_rb_d    = 4'hF;
          f_valc_d  = 64'h0;
          state_d   = ST_FETCH;
          if (newPC >= IMEM_LIMIT) pub_adr = 1'b1;
          else                     req_d   = 1'b1;
        end
      end
      default: ;
    endcase
    if (pub_ok || pub_adr) begin
      state_d = ST_OUT;
      valid_d = 1'b1;
      req_d   = 1'b0;
      icode_d = f_icode_d;
      ifun_d  = f_ifun_d;
      ra_d    = f_ra_d;
      rb_d    = f_rb_d;
      valc_d  = f_valc_d;
      valp_d  = pub_ok ? pc_d + 64'(len_d) : pc_d;
      if (pub_adr)                stat_d = STAT_ADR;
      else if (f_icode_d > 4'hB)  stat_d = STAT_INS;
      else if (f_icode_d == 4'h0) stat_d = STAT_HLT;
      else                        stat_d = STAT_AOK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      idx_q     <= 4'd0;
      len_q     <= 4'd1;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      f_icode_q <= 4'h0;
      f_ifun_q  <= 4'h0;
      f_ra_q    <= 4'hF;
      f_rb_q    <= 4'hF;
      f_valc_q  <= 64'h0;
      icode_q   <= 4'h0;
      ifun_q    <= 4'h0;
      ra_q      <= 4'hF;
      rb_q      <= 4'hF;
      valc_q    <= 64'h0;
      valp_q    <= 64'h0;
      stat_q    <= STAT_AOK;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      f_icode_q <= f_icode_d;
      f_ifun_q  <= f_ifun_d;
      f_ra_q    <= f_ra_d;
      f_rb_q    <= f_rb_d;
      f_valc_q  <= f_valc_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      valc_q    <= valc_d;
      valp_q    <= valp_d;
      stat_q    <= stat_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      if (valid_q && out_ready) instr_cnt_q <= instr_cnt_q + 32'd1;
      if (req_q && !imem_ack)   wait_cnt_q  <= wait_cnt_q + 32'd1;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q + 64'(idx_q);
  assign out_valid = valid_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign stat      = stat_q;
  assign pc        = pc_q;

endmodule
